// File: rtl/keypad_scan.sv
// Column-scanned keypad controller: synchronises active-low rows, debounces press
// and release, reports the lowest-row key per column, optional auto-repeat.
module keypad_scan #(
   parameter int NROWS        = 4,
   parameter int NCOLS        = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int DB_CYCLES    = 250000,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   localparam int KW = (NROWS * NCOLS > 1) ? $clog2(NROWS * NCOLS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NROWS-1:0] row,
   output logic [NCOLS-1:0] col,
   output logic [KW-1:0]    keycode,
   output logic             keypressed,
   output logic             keystrobe,
   output logic             multi
);

   localparam int CW   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int DW   = $clog2(SCAN_DIV);
   localparam int BW   = $clog2(DB_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DB_HIT     = BW'(DB_CYCLES - 1);
   localparam logic [RW-1:0] R_DELAY    = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] R_RATE     = RW'(REPEAT_RATE);
   localparam logic [CW-1:0] COL_LAST   = CW'(NCOLS - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t           state_q, state_d;
   logic [NROWS-1:0] row_s1_q, rs_q;
   logic [CW-1:0]    col_idx_q, col_idx_d, col_next;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [BW-1:0]    db_q, db_d;
   logic [RW-1:0]    rpt_q, rpt_d, rpt_inc;
   logic             rpt_first_q, rpt_first_d;
   logic [NROWS-1:0] pat_q, pat_d;
   logic [KW-1:0]    cap_code_q, cap_code_d;
   logic             cap_multi_q, cap_multi_d;
   logic [KW-1:0]    keycode_q, keycode_d;
   logic             keypressed_q, keypressed_d;
   logic             keystrobe_q, keystrobe_d;
   logic             multi_q, multi_d;

   logic [3:0]       low_cnt;
   logic [2:0]       first_row;
   logic             found;
   logic [KW-1:0]    code_now;

   // Lowest-indexed low row wins; the count only feeds the multi-key flag.
   always_comb begin
      low_cnt   = '0;
      first_row = '0;
      found     = 1'b0;
      for (int unsigned r = 0; r < NROWS; r++) begin
         if (!rs_q[r]) begin
            low_cnt = low_cnt + 4'd1;
            if (!found) begin
               first_row = 3'(r);
               found     = 1'b1;
            end
         end
      end
      code_now = KW'(first_row) * KW'(NCOLS) + KW'(col_idx_q);
   end

   assign col_next = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
   assign rpt_inc  = rpt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      col_idx_d    = col_idx_q;
      dwell_d      = dwell_q;
      db_d         = db_q;
      rpt_d        = rpt_q;
      rpt_first_d  = rpt_first_q;
      pat_d        = pat_q;
      cap_code_d   = cap_code_q;
      cap_multi_d  = cap_multi_q;
      keycode_d    = keycode_q;
      keypressed_d = keypressed_q;
      keystrobe_d  = 1'b0;
      multi_d      = multi_q;
      unique case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (!(&rs_q)) begin
                  pat_d       = rs_q;
                  cap_code_d  = code_now;
                  cap_multi_d = (low_cnt > 4'd1);
                  db_d        = '0;
                  state_d     = DEBOUNCE;
               end else begin
                  col_idx_d = col_next;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs_q == pat_q) begin
               if (db_q == DB_HIT) begin
                  state_d      = HELD;
                  db_d         = '0;
                  keycode_d    = cap_code_q;
                  multi_d      = cap_multi_q;
                  keypressed_d = 1'b1;
                  keystrobe_d  = 1'b1;
                  rpt_d        = '0;
                  rpt_first_d  = 1'b1;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               state_d   = SCAN;
               col_idx_d = col_next;
               db_d      = '0;
               dwell_d   = '0;
            end
         end
         HELD: begin
            if (&rs_q) begin
               state_d = RELEASE;
               db_d    = '0;
            end else if (REPEAT_EN != 0) begin
               if (rpt_inc == (rpt_first_q ? R_DELAY : R_RATE)) begin
                  keystrobe_d = 1'b1;
                  rpt_d       = '0;
                  rpt_first_d = 1'b0;
               end else begin
                  rpt_d = rpt_inc;
               end
            end
         end
         RELEASE: begin
            if (&rs_q) begin
               if (db_q == DB_HIT) begin
                  state_d      = SCAN;
                  keypressed_d = 1'b0;
                  col_idx_d    = col_next;
                  dwell_d      = '0;
                  db_d         = '0;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               // Bounce back into the hold restarts the repeat delay from scratch.
               state_d     = HELD;
               db_d        = '0;
               rpt_d       = '0;
               rpt_first_d = 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= SCAN;
         row_s1_q     <= '1;
         rs_q         <= '1;
         col_idx_q    <= '0;
         dwell_q      <= '0;
         db_q         <= '0;
         rpt_q        <= '0;
         rpt_first_q  <= 1'b1;
         pat_q        <= '1;
         cap_code_q   <= '0;
         cap_multi_q  <= 1'b0;
         keycode_q    <= '0;
         keypressed_q <= 1'b0;
         keystrobe_q  <= 1'b0;
         multi_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_s1_q     <= row;
         rs_q         <= row_s1_q;
         col_idx_q    <= col_idx_d;
         dwell_q      <= dwell_d;
         db_q         <= db_d;
         rpt_q        <= rpt_d;
         rpt_first_q  <= rpt_first_d;
         pat_q        <= pat_d;
         cap_code_q   <= cap_code_d;
         cap_multi_q  <= cap_multi_d;
         keycode_q    <= keycode_d;
         keypressed_q <= keypressed_d;
         keystrobe_q  <= keystrobe_d;
         multi_q      <= multi_d;
      end
   end

   assign col        = ~(NCOLS'(1) << col_idx_q);
   assign keycode    = keycode_q;
   assign keypressed = keypressed_q;
   assign keystrobe  = keystrobe_q;
   assign multi      = multi_q;

endmodule
